// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared funct3 codes, FSM states and byte-lane helpers for dm_lsu
package dm_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] off);
        case (funct3)
            F3_B:    be_gen = 4'b0001 << off;
            F3_H:    be_gen = off[1] ? 4'b1100 : 4'b0011;
            F3_W:    be_gen = 4'b1111;
            default: be_gen = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] ld_ext(input logic [31:0] word, input logic [2:0] funct3,
                                           input logic [1:0] off);
        logic [31:0] sh;
        sh = word >> {off, 3'b000};
        case (funct3)
            F3_B:    ld_ext = {{24{sh[7]}}, sh[7:0]};
            F3_H:    ld_ext = {{16{sh[15]}}, sh[15:0]};
            F3_W:    ld_ext = word;
            F3_BU:   ld_ext = {24'h0, sh[7:0]};
            F3_HU:   ld_ext = {16'h0, sh[15:0]};
            default: ld_ext = 32'h0;
        endcase
    endfunction

    function automatic logic f3_illegal(input logic we, input logic [2:0] funct3);
        if (we)
            f3_illegal = (funct3 > F3_W);
        else
            f3_illegal = (funct3 == 3'b011) || (funct3[2:1] == 2'b11);
    endfunction

    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] off);
        misaligned = ((funct3[1:0] == 2'b01) && off[0]) ||
                     ((funct3[1:0] == 2'b10) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// rtl/dm_lsu_if.sv - request/response handshake bundle between the MEM stage and dm_lsu
interface dm_lsu_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_byte_ram.sv
// rtl/dm_byte_ram.sv - four byte-wide synchronous RAM lanes, shared address, registered read
module dm_byte_ram #(
    parameter int ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic [3:0]           we,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [31:0]          wdata,
    output logic [31:0]          rdata
);
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] mem [2**ADDR_BITS];
        logic [7:0] rd_q;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we[g])
                    mem[addr] <= wdata[8*g +: 8];
                rd_q <= mem[addr];
            end
        end

        assign rdata[8*g +: 8] = rd_q;
    end
endmodule

// File: rtl/dm_lsu.sv
// rtl/dm_lsu.sv - RV32 load/store unit over a byte-lane data RAM with wait states
// Build option: DM_MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int ADDR_BITS   = 12,
    parameter int WAIT_STATES = 0
) (
    input  logic    clk,
    input  logic    rst_n,
    dm_lsu_if.slave bus
);
    localparam logic [3:0] WLAST = 4'(WAIT_STATES);

    state_t                state_q, state_d;
    logic [3:0]            wcnt_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_BITS-1:0]  widx_q;
    logic [1:0]            off_q;
    logic [31:0]           wdata_q;
    logic                  err_q;

    logic                  ready;
    logic                  accept;
    logic                  last;
    logic                  ram_en;
    logic [3:0]            ram_we;
    logic [31:0]           ram_wdata;
    logic [31:0]           ram_rdata;
    logic [1:0]            off_in;
    logic [1:0]            off_eff;
    logic                  err_in;
    logic                  unused_addr;

    assign unused_addr = ^bus.req_addr[31:ADDR_BITS+2];
    assign off_in      = bus.req_addr[1:0];

`ifdef DM_MISALIGN_TRAP_EN
    assign err_in  = f3_illegal(bus.req_we, bus.req_funct3) || misaligned(bus.req_funct3, off_in);
    assign off_eff = off_in;
`else
    // Misaligned accesses are silently aligned down to their natural boundary.
    assign err_in  = f3_illegal(bus.req_we, bus.req_funct3);
    assign off_eff = (bus.req_funct3[1:0] == 2'b01) ? {off_in[1], 1'b0} :
                     (bus.req_funct3[1:0] == 2'b10) ? 2'b00 : off_in;
`endif

    assign ready  = rst_n && ((state_q == IDLE) || (state_q == RESP));
    assign accept = bus.req_valid && ready;
    assign last   = (wcnt_q == WLAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        ram_en  = 1'b0;
        case (state_q)
            IDLE:   if (accept) state_d = ACCESS;
            ACCESS: if (last) begin
                        ram_en  = !err_q;
                        state_d = RESP;
                    end
            RESP:   state_d = accept ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcnt_q  <= 4'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            widx_q  <= '0;
            off_q   <= 2'd0;
            wdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else if (accept) begin
            wcnt_q  <= 4'd0;
            we_q    <= bus.req_we;
            f3_q    <= bus.req_funct3;
            widx_q  <= bus.req_addr[ADDR_BITS+1:2];
            off_q   <= off_eff;
            wdata_q <= bus.req_wdata;
            err_q   <= err_in;
        end else if ((state_q == ACCESS) && !last) begin
            wcnt_q  <= wcnt_q + 4'd1;
        end
    end

    assign ram_we    = we_q ? be_gen(f3_q, off_q) : 4'b0000;
    assign ram_wdata = (f3_q[1:0] == 2'b00) ? {4{wdata_q[7:0]}} :
                       (f3_q[1:0] == 2'b01) ? {2{wdata_q[15:0]}} : wdata_q;

    dm_byte_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (widx_q),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    assign bus.req_ready = ready;
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_rdata = ((state_q == RESP) && !we_q && !err_q) ? ld_ext(ram_rdata, f3_q, off_q) : 32'h0;
endmodule

// File: tb/tb_dm_lsu.sv
// tb/tb_dm_lsu.sv - directed self-checking bench for dm_lsu with zero and three wait states
module tb_dm_lsu;
    import dm_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    dm_lsu_if if0 ();
    dm_lsu_if if3 ();

    dm_lsu #(.ADDR_BITS(12), .WAIT_STATES(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    dm_lsu #(.ADDR_BITS(12), .WAIT_STATES(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int sel, input logic v, input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
        if (sel == 0) begin
            if0.req_valid = v; if0.req_we = we; if0.req_funct3 = f3;
            if0.req_addr = a; if0.req_wdata = wd;
        end else begin
            if3.req_valid = v; if3.req_we = we; if3.req_funct3 = f3;
            if3.req_addr = a; if3.req_wdata = wd;
        end
    endtask

    function automatic logic vld(input int sel);
        return (sel == 0) ? if0.rsp_valid : if3.rsp_valid;
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? if0.req_ready : if3.req_ready;
    endfunction

    function automatic logic [31:0] rdat(input int sel);
        return (sel == 0) ? if0.rsp_rdata : if3.rsp_rdata;
    endfunction

    function automatic logic rerr(input int sel);
        return (sel == 0) ? if0.rsp_err : if3.rsp_err;
    endfunction

    // One request, inputs dropped right after the accept edge; checks latency and pulse width.
    task automatic xfer(input string tag, input int sel, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        int nrdy;
        int w;
        w = (sel == 0) ? 0 : 3;
        @(negedge clk);
        set_req(sel, 1'b1, we, f3, a, wd);
        @(posedge clk); #1;
        set_req(sel, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        lat = 0;
        nrdy = 0;
        while (!vld(sel) && lat < 40) begin
            if (!rdy(sel)) nrdy++;
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(w + 1));
        chk({tag, "_rdata"}, rdat(sel), exp_rd);
        chk({tag, "_err"}, {31'h0, rerr(sel)}, {31'h0, exp_err});
        if (sel != 0) chk({tag, "_notready"}, 32'(nrdy), 32'(w + 1));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, {31'h0, vld(sel)}, 32'h0);
    endtask

    initial begin
        int n;
        set_req(0, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        set_req(3, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        #3;
        chk("rst_ready", {31'h0, if0.req_ready}, 32'h0);
        chk("rst_valid", {31'h0, if0.rsp_valid}, 32'h0);
        chk("rst_rdata", if0.rsp_rdata, 32'h0);
        chk("rst_err", {31'h0, if0.rsp_err}, 32'h0);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("idle_ready", {31'h0, if0.req_ready}, 32'h1);

        xfer("sw10", 0, 1'b1, F3_W, 32'h10, 32'h80FF7F01, 32'h0, 1'b0);
        xfer("lb10", 0, 1'b0, F3_B, 32'h10, 32'h0, 32'h00000001, 1'b0);
        xfer("lb13", 0, 1'b0, F3_B, 32'h13, 32'h0, 32'hFFFFFF80, 1'b0);
        xfer("lbu13", 0, 1'b0, F3_BU, 32'h13, 32'h0, 32'h00000080, 1'b0);
        xfer("lh12", 0, 1'b0, F3_H, 32'h12, 32'h0, 32'hFFFF80FF, 1'b0);
        xfer("lhu12", 0, 1'b0, F3_HU, 32'h12, 32'h0, 32'h000080FF, 1'b0);
        xfer("lw10", 0, 1'b0, F3_W, 32'h10, 32'h0, 32'h80FF7F01, 1'b0);

        xfer("sw20", 0, 1'b1, F3_W, 32'h20, 32'h0, 32'h0, 1'b0);
        xfer("sb21", 0, 1'b1, F3_B, 32'h21, 32'h000000AB, 32'h0, 1'b0);
        xfer("sh22", 0, 1'b1, F3_H, 32'h22, 32'h00001234, 32'h0, 1'b0);
        xfer("lw20", 0, 1'b0, F3_W, 32'h20, 32'h0, 32'h1234AB00, 1'b0);

        xfer("st011", 0, 1'b1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0, 1'b1);
        xfer("lw20_kept", 0, 1'b0, F3_W, 32'h20, 32'h0, 32'h1234AB00, 1'b0);
        xfer("ld110", 0, 1'b0, 3'b110, 32'h20, 32'h0, 32'h0, 1'b1);
`ifdef DM_MISALIGN_TRAP_EN
        xfer("lw21", 0, 1'b0, F3_W, 32'h21, 32'h0, 32'h0, 1'b1);
        xfer("lh23", 0, 1'b0, F3_H, 32'h23, 32'h0, 32'h0, 1'b1);
        xfer("sh23", 0, 1'b1, F3_H, 32'h23, 32'h0000FFFF, 32'h0, 1'b1);
        xfer("lw20_trap", 0, 1'b0, F3_W, 32'h20, 32'h0, 32'h1234AB00, 1'b0);
`else
        xfer("lw21", 0, 1'b0, F3_W, 32'h21, 32'h0, 32'h1234AB00, 1'b0);
        xfer("lh23", 0, 1'b0, F3_H, 32'h23, 32'h0, 32'h00001234, 1'b0);
`endif

        xfer("sw4010", 0, 1'b1, F3_W, 32'h4010, 32'hDEADBEEF, 32'h0, 1'b0);
        xfer("lw10_alias", 0, 1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // W=3: latency, ready-low window, then a cancelled store
        xfer("w3_sw10", 3, 1'b1, F3_W, 32'h10, 32'hCAFEF00D, 32'h0, 1'b0);
        xfer("w3_lw10", 3, 1'b0, F3_W, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);

        @(negedge clk);
        set_req(3, 1'b1, 1'b1, F3_W, 32'h10, 32'h55555555);
        @(posedge clk); #1;
        set_req(3, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rstmid_valid", {31'h0, if3.rsp_valid}, 32'h0);
        chk("rstmid_ready", {31'h0, if3.req_ready}, 32'h0);
        @(posedge clk); @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        #1;
        chk("rstrel_ready", {31'h0, if3.req_ready}, 32'h1);
        n = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (if3.rsp_valid) n++;
        end
        chk("rstrel_novalid", 32'(n), 32'h0);
        xfer("w3_lw10_kept", 3, 1'b0, F3_W, 32'h10, 32'h0, 32'hCAFEF00D, 1'b0);

        // back-to-back: second request held valid through the first response
        @(negedge clk);
        set_req(3, 1'b1, 1'b1, F3_W, 32'h30, 32'h11223344);
        @(posedge clk); #1;
        set_req(3, 1'b1, 1'b0, F3_W, 32'h30, 32'h0);
        n = 0;
        while (!if3.rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_a_lat", 32'(n), 32'd4);
        chk("b2b_a_ready", {31'h0, if3.req_ready}, 32'h1);
        @(posedge clk); #1;
        set_req(3, 1'b0, 1'b0, 3'd0, 32'h0, 32'h0);
        chk("b2b_a_pulse", {31'h0, if3.rsp_valid}, 32'h0);
        n = 1;
        while (!if3.rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_gap", 32'(n), 32'd5);
        chk("b2b_b_rdata", if3.rsp_rdata, 32'h11223344);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
